// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg : shared state encoding and timing defaults for the array controller
// Revision 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } ctrl_state_t;

  localparam int DEF_ARRAY_ROWS   = 4;
  localparam int DEF_ARRAY_COLS   = 4;
  localparam int DEF_NODE_LATENCY = 2;
  localparam int DEF_ROW_STEP     = 1;
  localparam int DEF_COL_STEP     = 2;

  // Taps needed so the bottom-right result strobe is still inside the line.
  function automatic int delay_depth(input int rows, input int cols, input int lat,
                                     input int row_step, input int col_step);
    return lat + (rows - 1) * row_step + (cols - 1) * col_step + 1;
  endfunction

  localparam int DELAY_DEPTH = delay_depth(DEF_ARRAY_ROWS, DEF_ARRAY_COLS, DEF_NODE_LATENCY,
                                           DEF_ROW_STEP, DEF_COL_STEP);

endpackage

`default_nettype wire

// File: rtl/systolic_array_controller_if.sv
// ============================================================================
// systolic_array_controller_if : job, weight-memory and activation control bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface systolic_array_controller_if #(
  parameter int ARRAY_ROWS         = 4,
  parameter int ARRAY_COLS         = 4,
  parameter int VECTOR_COUNT_WIDTH = 8
);
  localparam int ADDR_W = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

  logic                          start_in;
  logic [VECTOR_COUNT_WIDTH-1:0] vector_count_in;
  logic                          busy_out;
  logic                          done_out;
  logic                          weight_rd_en_out;
  logic [ADDR_W-1:0]             weight_rd_addr_out;
  logic [ARRAY_ROWS-1:0]         weight_valid_out;
  logic                          act_valid_in;
  logic                          act_ready_out;
  logic [ARRAY_ROWS-1:0]         act_feed_en_out;
  logic [ARRAY_COLS-1:0]         result_valid_out;
  logic                          result_last_out;

  modport master (
    output start_in, vector_count_in, act_valid_in,
    input  busy_out, done_out, weight_rd_en_out, weight_rd_addr_out, weight_valid_out,
    input  act_ready_out, act_feed_en_out, result_valid_out, result_last_out
  );

  modport slave (
    input  start_in, vector_count_in, act_valid_in,
    output busy_out, done_out, weight_rd_en_out, weight_rd_addr_out, weight_valid_out,
    output act_ready_out, act_feed_en_out, result_valid_out, result_last_out
  );

endinterface

`default_nettype wire

// File: rtl/systolic_valid_delay_line.sv
// ============================================================================
// systolic_valid_delay_line : tapped shift register carrying {last, valid} tags
// Revision 1.0
// ============================================================================
`default_nettype none

module systolic_valid_delay_line #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [WIDTH-1:0]            data_in,
  output logic [DEPTH-1:0][WIDTH-1:0] taps_out
);

  logic [DEPTH-1:1][WIDTH-1:0] r_stage;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_stage <= '0;
    end else begin
      r_stage[1] <= data_in;
      for (int k = 2; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  // Tap 0 is the undelayed input so row 0 can be fed in the accept cycle.
  always_comb begin
    taps_out[0] = data_in;
    for (int k = 1; k < DEPTH; k++) begin
      taps_out[k] = r_stage[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_array_controller.sv
// ============================================================================
// systolic_array_controller : per-job weight load, skewed activation feed and result strobes
// Revision 1.0
// ============================================================================
`default_nettype none

module systolic_array_controller
  import systolic_pkg::*;
#(
  parameter int ARRAY_ROWS         = DEF_ARRAY_ROWS,
  parameter int ARRAY_COLS         = DEF_ARRAY_COLS,
  parameter int VECTOR_COUNT_WIDTH = 8,
  parameter int NODE_LATENCY       = DEF_NODE_LATENCY,
  parameter int ROW_STEP           = DEF_ROW_STEP,
  parameter int COL_STEP           = DEF_COL_STEP
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  systolic_array_controller_if.slave ctrl
);

  localparam int DEPTH    = delay_depth(ARRAY_ROWS, ARRAY_COLS, NODE_LATENCY, ROW_STEP, COL_STEP);
  localparam int RES_BASE = NODE_LATENCY + (ARRAY_ROWS - 1) * ROW_STEP;
  localparam int RCW      = $clog2(ARRAY_ROWS + 1);
  localparam int AW       = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;

  ctrl_state_t                   r_state;
  ctrl_state_t                   w_state_next;
  logic [RCW-1:0]                r_row_cnt;
  logic [VECTOR_COUNT_WIDTH-1:0] r_remaining;
  logic [ARRAY_ROWS-1:0]         r_weight_valid;
  logic                          w_loading;
  logic                          w_ready;
  logic                          w_accept;
  logic                          w_last_accept;
  logic                          w_pending;
  logic [DEPTH-1:0][1:0]         w_taps;
  logic [ARRAY_ROWS-1:0]         w_feed;
  logic [ARRAY_COLS-1:0]         w_result;

  assign w_loading     = (r_state == LOAD) && (r_row_cnt < RCW'(ARRAY_ROWS));
  assign w_ready       = (r_state == STREAM) && (r_remaining != '0);
  assign w_accept      = ctrl.act_valid_in && w_ready;
  assign w_last_accept = w_accept && (r_remaining == VECTOR_COUNT_WIDTH'(1));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state        <= IDLE;
      r_row_cnt      <= '0;
      r_remaining    <= '0;
      r_weight_valid <= '0;
    end else begin
      r_state        <= w_state_next;
      // Weight read data lags the address by one cycle, so the row strobe does too.
      r_weight_valid <= w_loading ? (ARRAY_ROWS'(1) << r_row_cnt) : '0;
      if ((r_state == IDLE) && ctrl.start_in) begin
        r_row_cnt   <= '0;
        r_remaining <= ctrl.vector_count_in;
      end else begin
        if (w_loading) r_row_cnt <= r_row_cnt + RCW'(1);
        if (w_accept)  r_remaining <= r_remaining - VECTOR_COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (ctrl.start_in) w_state_next = LOAD;
      LOAD:    if (r_row_cnt == RCW'(ARRAY_ROWS))
                 w_state_next = (r_remaining != '0) ? STREAM : DONE;
      STREAM:  if (w_last_accept) w_state_next = DRAIN;
      DRAIN:   if (!w_pending) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  systolic_valid_delay_line #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_delay_line (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data_in  ({w_last_accept, w_accept}),
    .taps_out (w_taps)
  );

  // Anything short of the final tap still owes a strobe, so DRAIN must hold.
  always_comb begin
    w_pending = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      w_pending = w_pending | (|w_taps[k]);
    end
  end

  always_comb begin
    w_feed   = '0;
    w_result = '0;
    for (int r = 0; r < ARRAY_ROWS; r++) w_feed[r] = w_taps[r*ROW_STEP][0];
    for (int c = 0; c < ARRAY_COLS; c++) w_result[c] = w_taps[RES_BASE + c*COL_STEP][0];
  end

  assign ctrl.busy_out           = (r_state != IDLE);
  assign ctrl.done_out           = (r_state == DONE);
  assign ctrl.weight_rd_en_out   = w_loading;
  assign ctrl.weight_rd_addr_out = w_loading ? r_row_cnt[AW-1:0] : '0;
  assign ctrl.weight_valid_out   = r_weight_valid;
  assign ctrl.act_ready_out      = w_ready;
  assign ctrl.act_feed_en_out    = w_feed;
  assign ctrl.result_valid_out   = w_result;
  assign ctrl.result_last_out    = w_taps[RES_BASE + (ARRAY_COLS-1)*COL_STEP][1];

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_controller.sv
// ============================================================================
// tb_systolic_array_controller : directed vectors for the 4x4 array controller
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_systolic_array_controller;

  localparam int R   = 4;
  localparam int C   = 4;
  localparam int VCW = 8;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  systolic_array_controller_if #(.ARRAY_ROWS(R), .ARRAY_COLS(C), .VECTOR_COUNT_WIDTH(VCW)) bus ();

  systolic_array_controller #(
    .ARRAY_ROWS         (R),
    .ARRAY_COLS         (C),
    .VECTOR_COUNT_WIDTH (VCW)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .ctrl     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // {busy, done, rd_en, addr[1:0], wvalid[3:0], ready, feed[3:0], rvalid[3:0], last}
  logic [18:0] w_obs;
  assign w_obs = {bus.busy_out, bus.done_out, bus.weight_rd_en_out, bus.weight_rd_addr_out,
                  bus.weight_valid_out, bus.act_ready_out, bus.act_feed_en_out,
                  bus.result_valid_out, bus.result_last_out};

  typedef struct {
    logic        start;
    logic        av;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [18:0] mk(input logic busy, input logic done, input logic rden,
                                     input logic [1:0] addr, input logic [3:0] wv,
                                     input logic rdy, input logic [3:0] feed,
                                     input logic [3:0] rv, input logic last);
    return {busy, done, rden, addr, wv, rdy, feed, rv, last};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one job from IDLE and compares every cycle against a timeline model.
  task automatic run_job(input string name, input int cnt, input logic [15:0] pat,
                         input int plen, input logic hold);
    int acc[16];
    int n      = 0;
    int a_last = -1;
    int dc;
    logic [3:0] feed, rv, wv;
    logic [1:0] addr;
    for (int i = 0; i < 32; i++) begin
      logic v;
      v = (i < plen) ? pat[i] : 1'b1;
      if (v && (n < cnt) && (n < 16)) begin
        acc[n] = 5 + i;
        n++;
      end
    end
    if (cnt == 0) dc = 5;
    else begin
      a_last = acc[n-1];
      dc     = a_last + 12;
    end
    bus.start_in        = 1'b1;
    bus.vector_count_in = VCW'(cnt);
    bus.act_valid_in    = 1'b1;
    @(negedge clk_in);
    check({name, "_idle"}, 0, 32'(w_obs), 32'(0));
    step();
    for (int k = 0; k <= dc + 1; k++) begin
      bus.start_in     = hold;
      bus.act_valid_in = (k >= 5 && (k - 5) < plen) ? pat[k-5] : 1'b1;
      feed = '0;
      rv   = '0;
      for (int i = 0; i < n; i++) begin
        for (int r = 0; r < R; r++) if (acc[i] + r == k) feed[r] = 1'b1;
        for (int c = 0; c < C; c++) if (acc[i] + 5 + 2*c == k) rv[c] = 1'b1;
      end
      addr = (k < 4) ? k[1:0] : 2'd0;
      wv   = (k >= 1 && k <= 4) ? 4'(1 << (k - 1)) : 4'd0;
      @(negedge clk_in);
      check(name, k, 32'(w_obs),
            32'(mk(k <= dc, k == dc, k < 4, addr, wv, (cnt > 0) && k >= 5 && k <= a_last,
                   feed, rv, (cnt > 0) && (k == a_last + 11))));
      step();
    end
    bus.start_in = 1'b0;
  endtask

  initial begin
    int bad;
    tbl[0]  = '{1'b1, 1'b1, mk(1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[1]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b1,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[2]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b1,2'd1,4'b0001,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[3]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b1,2'd2,4'b0010,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[4]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b1,2'd3,4'b0100,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[5]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b1000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[6]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b1,4'b0001,4'b0000,1'b0)};
    tbl[7]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0010,4'b0000,1'b0)};
    tbl[8]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0100,4'b0000,1'b0)};
    tbl[9]  = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b1000,4'b0000,1'b0)};
    tbl[10] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[11] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0001,1'b0)};
    tbl[12] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[13] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0010,1'b0)};
    tbl[14] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[15] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0100,1'b0)};
    tbl[16] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[17] = '{1'b0, 1'b1, mk(1'b1,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b1000,1'b1)};
    tbl[18] = '{1'b0, 1'b1, mk(1'b1,1'b1,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};
    tbl[19] = '{1'b0, 1'b1, mk(1'b0,1'b0,1'b0,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)};

    bus.start_in        = 1'b0;
    bus.vector_count_in = '0;
    bus.act_valid_in    = 1'b0;
    step();
    step();
    @(negedge clk_in);
    check("reset_state", 0, 32'(w_obs), 32'(0));
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    step();

    // count=1, activation source always ready
    for (int i = 0; i < 20; i++) begin
      bus.start_in        = tbl[i].start;
      bus.vector_count_in = VCW'(1);
      bus.act_valid_in    = tbl[i].av;
      @(negedge clk_in);
      check("job_count1", i, 32'(w_obs), 32'(tbl[i].exp));
      step();
    end

    run_job("bubbles", 3, 16'b10101, 5, 1'b0);
    run_job("count0", 0, 16'h0000, 0, 1'b0);

    // start held high: one job, then a fresh job only once back in IDLE
    run_job("start_held", 1, 16'h0000, 0, 1'b1);
    @(negedge clk_in);
    check("start_held_relaunch", 0, 32'(w_obs),
          32'(mk(1'b1,1'b0,1'b1,2'd0,4'b0000,1'b0,4'b0000,4'b0000,1'b0)));
    step();
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;

    // abort mid-STREAM with vectors in flight
    bus.start_in        = 1'b1;
    bus.vector_count_in = VCW'(5);
    bus.act_valid_in    = 1'b1;
    step();
    bus.start_in = 1'b0;
    for (int k = 0; k < 7; k++) step();
    @(negedge clk_in);
    check("mid_stream_ready", 0, 32'(bus.act_ready_out), 32'(1));
    step();
    rst_n_in = 1'b0;
    step();
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("reset_mid_stream", 0, 32'(w_obs), 32'(0));
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      @(negedge clk_in);
      if (w_obs !== 19'd0) bad++;
    end
    check("post_reset_quiet_cycles", 0, 32'(bad), 32'(0));
    step();
    run_job("restart", 2, 16'h0000, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
